// File: rtl/pool_pkg.sv
// ---------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the 2x2 max-pool block: the frame FSM state enum,
// default geometry/precision constants, the coordinate width used by the
// pooled x/y outputs, and a helper that locates a channel inside a packed
// beat (channel 0 occupies the most significant activation slot).
// ---------------------------------------------------------------------------
package pool_pkg;

   localparam int DEF_CH_NUM     = 4;
   localparam int DEF_BW_PER_ACT = 8;
   localparam int DEF_MAP_W      = 4;
   localparam int DEF_MAP_H      = 4;

   // Width of the raster counters and the pooled coordinate outputs.
   localparam int COORD_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } poolState_e;

   // Channel 0 sits in the top slot, so channel c starts at (chNum-1-c)*bw.
   function automatic int laneLsb(input int ch, input int chNum, input int bw);
      return (chNum - 1 - ch) * bw;
   endfunction

endpackage

// File: rtl/max_pool_2x2_if.sv
// ---------------------------------------------------------------------------
// max_pool_2x2_if
// Bundles the pixel stream in and the pooled stream out of max_pool_2x2.
//   start      : one-cycle pulse arming a new frame
//   in_valid   : in_data holds a valid pixel beat
//   in_data    : CH_NUM packed signed activations, channel 0 in the MSBs
//   busy       : frame currently being accepted
//   out_valid  : one-cycle pooled-pixel strobe
//   out_data   : pooled pixel, same packing as in_data
//   out_x/out_y: pooled column/row index
//   frame_done : one-cycle pulse alongside the last pooled pixel
// Modport slave is the pooling block, master is the pixel producer/consumer.
// ---------------------------------------------------------------------------
interface max_pool_2x2_if
   import pool_pkg::*;
#(
   parameter int CH_NUM     = DEF_CH_NUM,
   parameter int BW_PER_ACT = DEF_BW_PER_ACT
);

   logic                           start;
   logic                           in_valid;
   logic [CH_NUM*BW_PER_ACT-1:0]   in_data;
   logic                           busy;
   logic                           out_valid;
   logic [CH_NUM*BW_PER_ACT-1:0]   out_data;
   logic [COORD_W-1:0]             out_x;
   logic [COORD_W-1:0]             out_y;
   logic                           frame_done;

   modport master (
      output start, in_valid, in_data,
      input  busy, out_valid, out_data, out_x, out_y, frame_done
   );

   modport slave (
      input  start, in_valid, in_data,
      output busy, out_valid, out_data, out_x, out_y, frame_done
   );

endinterface

// File: rtl/pool_max_lane.sv
// ---------------------------------------------------------------------------
// pool_max_lane
// Per-channel datapath for 2x2 max pooling, purely combinational.
//   act_i      : incoming raw signed activation for this channel
//   pairHold_i : registered (already clamped) activation from the even column
//   rowEntry_i : pair maximum stored from the even row above
//   actClamp_o : incoming activation after the optional ReLU clamp
//   pairMax_o  : max(pairHold_i, actClamp_o)
//   quadMax_o  : max(rowEntry_i, pairMax_o)
// Build option: define POOL_RELU_EN to clamp activations to max(value,0)
// before pooling; otherwise raw signed values are pooled.
// ---------------------------------------------------------------------------
module pool_max_lane
   import pool_pkg::*;
#(
   parameter int BW = DEF_BW_PER_ACT
)(
   input  logic signed [BW-1:0] act_i,
   input  logic signed [BW-1:0] pairHold_i,
   input  logic signed [BW-1:0] rowEntry_i,
   output logic signed [BW-1:0] actClamp_o,
   output logic signed [BW-1:0] pairMax_o,
   output logic signed [BW-1:0] quadMax_o
);

   // Clamp happens at the very input, so the held value, the row buffer
   // and the final result all live in the clamped domain.
`ifdef POOL_RELU_EN
   assign actClamp_o = act_i[BW-1] ? '0 : act_i;
`else
   assign actClamp_o = act_i;
`endif

   // Ties keep the earlier operand (left column, upper row); both operands
   // are then equal, so the result is bit-identical either way.
   assign pairMax_o = (pairHold_i >= actClamp_o) ? pairHold_i : actClamp_o;
   assign quadMax_o = (rowEntry_i >= pairMax_o) ? rowEntry_i : pairMax_o;

endmodule

// File: rtl/max_pool_2x2.sv
// ---------------------------------------------------------------------------
// max_pool_2x2
// Streaming 2x2 / stride-2 max pooling over a MAP_W x MAP_H frame of
// CH_NUM-channel signed pixels arriving in raster order (x fastest).
//   clk : single clock, rising edge
//   rst : asynchronous active-high reset
//   bus : max_pool_2x2_if.slave -- start/in_valid/in_data in,
//         busy/out_valid/out_data/out_x/out_y/frame_done out
// Even columns are held in a register, odd columns form the horizontal pair
// max; even rows park the pair max in a MAP_W/2 row buffer, odd rows combine
// it with the buffered value and emit the pooled pixel one cycle later.
// Build option: POOL_RELU_EN (see pool_max_lane) clamps inputs to >= 0.
// ---------------------------------------------------------------------------
module max_pool_2x2
   import pool_pkg::*;
#(
   parameter int CH_NUM     = DEF_CH_NUM,
   parameter int BW_PER_ACT = DEF_BW_PER_ACT,
   parameter int MAP_W      = DEF_MAP_W,
   parameter int MAP_H      = DEF_MAP_H
)(
   input logic           clk,
   input logic           rst,
   max_pool_2x2_if.slave bus
);

   localparam int DW       = CH_NUM * BW_PER_ACT;
   localparam int RB_DEPTH = MAP_W / 2;
   localparam int RB_AW    = (RB_DEPTH > 1) ? $clog2(RB_DEPTH) : 1;
   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(MAP_W - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(MAP_H - 1);

   poolState_e         state_q, state_d;
   logic [COORD_W-1:0] xCnt_q, xCnt_d;
   logic [COORD_W-1:0] yCnt_q, yCnt_d;
   logic [DW-1:0]      hold_q, hold_d;
   logic [DW-1:0]      outData_q, outData_d;
   logic [COORD_W-1:0] outX_q, outX_d;
   logic [COORD_W-1:0] outY_q, outY_d;
   logic               outValid_q, outValid_d;
   logic               frameDone_q, frameDone_d;
   logic [DW-1:0]      rowBuf_q [RB_DEPTH];

   logic               accept;
   logic               lastBeat;
   logic               rowWrite;
   logic [RB_AW-1:0]   rbIdx;
   logic [DW-1:0]      rowEntry;
   logic [DW-1:0]      actClamp;
   logic [DW-1:0]      pairMax;
   logic [DW-1:0]      quadMax;

   assign accept   = (state_q == RUN) && bus.in_valid;
   assign lastBeat = (xCnt_q == X_LAST) && (yCnt_q == Y_LAST);
   assign rbIdx    = xCnt_q[RB_AW:1];
   assign rowEntry = rowBuf_q[rbIdx];

   // One lane per channel; the slice position follows the beat packing.
   for (genvar c = 0; c < CH_NUM; c++) begin : gLane
      localparam int LSB = laneLsb(c, CH_NUM, BW_PER_ACT);
      pool_max_lane #(.BW(BW_PER_ACT)) uLane (
         .act_i      (bus.in_data[LSB +: BW_PER_ACT]),
         .pairHold_i (hold_q[LSB +: BW_PER_ACT]),
         .rowEntry_i (rowEntry[LSB +: BW_PER_ACT]),
         .actClamp_o (actClamp[LSB +: BW_PER_ACT]),
         .pairMax_o  (pairMax[LSB +: BW_PER_ACT]),
         .quadMax_o  (quadMax[LSB +: BW_PER_ACT])
      );
   end

   // Frame FSM: start only matters in IDLE, the final accepted beat ends the
   // frame, and DONE is a single bookkeeping cycle back to IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (accept && lastBeat) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next state. Nothing moves unless a beat is accepted, so gaps
   // in in_valid are pure stalls. The pooled outputs keep their last value
   // between strobes; only the strobes default low.
   always_comb begin
      xCnt_d      = xCnt_q;
      yCnt_d      = yCnt_q;
      hold_d      = hold_q;
      outData_d   = outData_q;
      outX_d      = outX_q;
      outY_d      = outY_q;
      outValid_d  = 1'b0;
      frameDone_d = 1'b0;
      rowWrite    = 1'b0;
      if ((state_q == IDLE) && bus.start) begin
         xCnt_d = '0;
         yCnt_d = '0;
      end
      if (accept) begin
         if (!xCnt_q[0]) begin
            hold_d = actClamp;
         end else if (!yCnt_q[0]) begin
            rowWrite = 1'b1;
         end else begin
            outData_d   = quadMax;
            outX_d      = xCnt_q >> 1;
            outY_d      = yCnt_q >> 1;
            outValid_d  = 1'b1;
            frameDone_d = lastBeat;
         end
         if (xCnt_q == X_LAST) begin
            xCnt_d = '0;
            yCnt_d = (yCnt_q == Y_LAST) ? '0 : yCnt_q + 1'b1;
         end else begin
            xCnt_d = xCnt_q + 1'b1;
         end
      end
   end

   // All control and output state clears immediately on reset so a frame
   // interrupted mid-way leaves no pending strobe behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         xCnt_q      <= '0;
         yCnt_q      <= '0;
         hold_q      <= '0;
         outData_q   <= '0;
         outX_q      <= '0;
         outY_q      <= '0;
         outValid_q  <= 1'b0;
         frameDone_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         xCnt_q      <= xCnt_d;
         yCnt_q      <= yCnt_d;
         hold_q      <= hold_d;
         outData_q   <= outData_d;
         outX_q      <= outX_d;
         outY_q      <= outY_d;
         outValid_q  <= outValid_d;
         frameDone_q <= frameDone_d;
      end
   end

   // Row buffer has no reset: every entry is rewritten on an even row before
   // the odd row below reads it, so stale contents never reach an output.
   always_ff @(posedge clk) begin
      if (rowWrite) begin
         rowBuf_q[rbIdx] <= pairMax;
      end
   end

   assign bus.busy       = (state_q == RUN);
   assign bus.out_valid  = outValid_q;
   assign bus.out_data   = outData_q;
   assign bus.out_x      = outX_q;
   assign bus.out_y      = outY_q;
   assign bus.frame_done = frameDone_q;

endmodule
